// File: rtl/shift_unit.sv
// Pipelined log-depth shift/rotate unit with valid/ready handshake and bubble collapse.
// Optional rotate-left on op 11 is enabled by defining SHIFT_ROTATE_EN.
module shift_unit #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_c,
    output logic                       out_zero
);

    localparam int SW = $clog2(WIDTH);
    localparam int L  = (SW + REG_EVERY - 1) / REG_EVERY;
    localparam int PL = (L > 1) ? L - 1 : 1;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] OP_ROL = 2'b11;
`endif

    // One mux level: shift by a fixed power of two. SRA keeps replicating the
    // MSB, which stays equal to the original sign bit at every level.
    function automatic logic [WIDTH-1:0] shiftLevel(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input int unsigned      amt);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | (d[WIDTH-1] ? ~({WIDTH{1'b1}} >> amt) : '0);
`ifdef SHIFT_ROTATE_EN
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
`endif
            default: r = d << amt;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] data_q  [L];
    logic [WIDTH-1:0] data_d  [L];
    logic [L-1:0]     valid_q;
    logic [L-1:0]     valid_d;
    logic [SW-1:0]    shamt_q [PL];
    logic [SW-1:0]    shamt_d [PL];
    logic [1:0]       op_q    [PL];
    logic [1:0]       op_d    [PL];
    logic             zero_q;
    logic             zero_d;
    logic [L-1:0]     advance;

    // Each stage applies its own group of REG_EVERY levels to the data coming
    // from the previous stage register (or the input port for stage 0).
    for (genvar k = 0; k < L; k++) begin : gStage
        logic [WIDTH-1:0] stageIn;
        logic [WIDTH-1:0] stageOut;
        logic [SW-1:0]    stageShamt;
        logic [1:0]       stageOp;
        logic             stageValid;

        if (k == 0) begin : gFirst
            assign stageIn    = in_a;
            assign stageShamt = in_shamt;
            assign stageOp    = in_op;
            assign stageValid = in_valid;
        end else begin : gRest
            assign stageIn    = data_q[k-1];
            assign stageShamt = shamt_q[k-1];
            assign stageOp    = op_q[k-1];
            assign stageValid = valid_q[k-1];
        end

        always_comb begin
            stageOut = stageIn;
            for (int j = 0; j < SW; j++) begin
                if ((j / REG_EVERY) == k && stageShamt[j]) begin
                    stageOut = shiftLevel(stageOut, stageOp, 32'd1 << j);
                end
            end
        end

        assign data_d[k]  = stageOut;
        assign valid_d[k] = stageValid;

        if (k < L - 1) begin : gCarry
            assign shamt_d[k] = stageShamt;
            assign op_d[k]    = stageOp;
        end
    end

    assign zero_d = (data_d[L-1] == '0);

    // A stage may load whenever some stage at or below it holds a bubble, or
    // the consumer is taking the output; this is the collapsed ready chain.
    always_comb begin
        logic bubbleBelow;
        advance     = '0;
        bubbleBelow = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            bubbleBelow = bubbleBelow || !valid_q[k];
            advance[k]  = bubbleBelow;
        end
    end

    // Stage registers; payload only loads with a valid operation so the output
    // keeps the last result when a bubble passes through.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < L; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < PL; k++) begin
                shamt_q[k] <= '0;
                op_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (advance[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end
            for (int k = 0; k < L - 1; k++) begin
                if (advance[k] && valid_d[k]) begin
                    shamt_q[k] <= shamt_d[k];
                    op_q[k]    <= op_d[k];
                end
            end
            if (advance[L-1] && valid_d[L-1]) begin
                zero_q <= zero_d;
            end
        end
    end

    assign in_ready  = advance[0];
    assign out_valid = valid_q[L-1];
    assign out_c     = data_q[L-1];
    assign out_zero  = zero_q;

endmodule
